// File: rtl/serial_tx_framer.sv
// Asynchronous serial frame transmitter: start bit, DATA_BITS data bits LSB-first,
// optional even parity (define SERIAL_TX_PARITY_EN), STOP_BITS stop bits, paced by baud_tick.
module serial_tx_framer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IDXW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARM    = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif
  localparam logic [2:0] STOP   = 3'd5;

  logic [2:0]           state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [IDXW-1:0]      bit_idx, bit_idx_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 done_n;
  logic                 serial_n;
`ifdef SERIAL_TX_PARITY_EN
  logic                 par_bit, par_bit_n;
`endif

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    done_n     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_bit_n  = par_bit;
`endif
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_n    = ARM;
          shreg_n    = tx_data;
          bit_idx_n  = '0;
          stop_cnt_n = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          par_bit_n  = ^tx_data;
`endif
        end
      end
      // ARM is only entered on the accept edge, so a tick seen there always belongs
      // to a later cycle; the start bit therefore spans a full bit period.
      ARM: begin
        if (baud_tick) state_n = START;
      end
      START: begin
        if (baud_tick) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shreg_n = shreg >> 1;
          if (bit_idx == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
            stop_cnt_n = 1'b0;
          end else begin
            bit_idx_n = bit_idx + IDXW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_n    = STOP;
          stop_cnt_n = 1'b0;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt == LAST_STOP) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the registered output moves on the
  // same edge as the state, one clk after the tick.
  always_comb begin
    serial_n = 1'b1;
    case (state_n)
      START:   serial_n = 1'b0;
      DATA:    serial_n = shreg_n[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  serial_n = par_bit_n;
`endif
      default: serial_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_idx   <= bit_idx_n;
      stop_cnt  <= stop_cnt_n;
      tx_serial <= serial_n;
      tx_ready  <= (state_n == IDLE);
      tx_busy   <= (state_n != IDLE);
      tx_done   <= done_n;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_bit <= 1'b0;
    else        par_bit <= par_bit_n;
  end
`endif

endmodule
